dummy_accelerator_arbiter: RTL
==============================

Name: dummy_accelerator_arbiter

Overview:
Shares one dummy accelerator instance between NumReq requesters (issue ports), with one operation in flight at a time. Arbitration is round-robin. The block latches the winning request, issues it to the accelerator's upstream valid/ready port, and routes the accelerator result back only to the owning requester. It sits between the core-side issue interfaces and the accelerator top level.

Parameters:
NumReq, 2, number of requesters (2..8)
CtlWidth, 32, width of ctl word passed to accelerator
DataWidth, 32, operand/result width
IdWidth, $clog2(NumReq) (min 1), width of owner id

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush; abort in-flight operation
req_valid_i  in  NumReq  per-requester request valid
req_ready_o  out  NumReq  per-requester accept (at most one bit high)
req_ctl_i  in  NumReq*CtlWidth  packed ctl words, requester i at slice i
req_data_i  in  NumReq*DataWidth  packed operands
rsp_valid_o  out  NumReq  one-hot result valid to owner
rsp_ready_i  in  NumReq  per-requester result ready
rsp_data_o  out  DataWidth  shared result bus
acc_valid_o  out  1  request valid to accelerator
acc_ready_i  in  1  accelerator ready
acc_ctl_o  out  CtlWidth  latched ctl
acc_data_o  out  DataWidth  latched operand
acc_valid_i  in  1  accelerator result valid
acc_ready_o  out  1  result ready to accelerator
acc_data_i  in  DataWidth  accelerator result
acc_flush_o  out  1  flush to accelerator (= flush_i, combinational)
busy_o  out  1  high when state != IDLE
owner_o  out  IdWidth  id of current owner (latched)
stall_cnt_o  out  16  stall statistics (see Optional Feature)

Behaviour:
- Reset values: state IDLE; all outputs 0; rr pointer 0; latched ctl/data/owner 0.
- FSM states: IDLE, ISSUE, WAIT_RSP.
- IDLE:
  - Grant g is the first requester with req_valid_i set, searching i = ptr, ptr+1, ... modulo NumReq.
  - req_ready_o[g] = 1 combinationally; all other ready bits stay 0.
  - On the handshake, latch req_ctl_i[g], req_data_i[g] and owner = g, then go to ISSUE.
  - With no valid requests, stay in IDLE.
- ISSUE:
  - acc_valid_o = 1 with the latched ctl/data. These values stay stable until acc_ready_i.
  - On acc_ready_i, go to WAIT_RSP.
  - Latency: acc_valid_o rises exactly 1 cycle after request acceptance.
- WAIT_RSP:
  - rsp_valid_o[owner] = acc_valid_i; rsp_data_o = acc_data_i.
  - acc_ready_o = rsp_ready_i[owner]; all other rsp_valid_o bits are 0.
  - On acc_valid_i && rsp_ready_i[owner], set ptr = (owner+1) mod NumReq and return to IDLE.
  - A new request cannot be accepted in the same cycle; the earliest acceptance is the following cycle.
- Round-robin pointer: updated only on response completion. A requester that holds valid continuously is served within NumReq operations.
- Combinational acc_valid_i in the same cycle as acc_ready_i (ISSUE state): ignored. The accelerator's upstream handshake completes first, and the result is sampled in WAIT_RSP, where the accelerator holds valid until ready.
- Accelerator results arriving in IDLE or ISSUE: acc_ready_o = 0, the result is not forwarded.
- flush_i (priority over all transitions):
  - Next state is IDLE; latched ctl/data/owner are cleared; ptr is unchanged.
  - In the flush cycle itself, req_ready_o and rsp_valid_o are forced to 0.
  - acc_flush_o mirrors flush_i.
- Reset mid-operation: immediate return to reset values, asynchronously.
- Requester dropping req_valid_i before acceptance: legal; it is simply not granted.
- NumReq = 1: degenerates to a registered pass-through; ptr stays 0.

Optional Feature:
Macro DUMMY_ACC_ARB_STALL_CNT_EN.
- Defined: stall_cnt_o is a 16-bit saturating counter (saturates at 0xFFFF). It increments every cycle in which any req_valid_i bit is 1 and no req_ready_o bit is 1. It is cleared by reset and by flush_i.
- Undefined: stall_cnt_o is tied to 0 and no counter logic is synthesised.
- The port list is identical in both builds.

Test Plan:
1. Single requester (req 0, ctl=3, data=0xA5), accel ready immediately, result 0x5A after 3 cycles -> acc_valid_o 1 cycle after accept; rsp_valid_o=01, rsp_data_o=0x5A; back to IDLE, busy_o=0.
2. NumReq=2, both valid continuously for 4 ops -> grants alternate 0,1,0,1; owner_o follows; req_ready_o never 2'b11.
3. Owner holds rsp_ready_i=0 for 5 cycles while acc_valid_i=1 -> acc_ready_o=0 and rsp_valid_o[owner] held for 5 cycles; completion on the 6th cycle; no new grant meanwhile.
4. flush_i asserted in WAIT_RSP -> acc_flush_o=1 same cycle; state IDLE next cycle; no rsp_valid_o; ptr unchanged (same requester wins next if it is still valid).
5. rst_ni pulsed low during ISSUE -> all outputs 0 immediately; after release, first grant goes to requester 0.
6. With DUMMY_ACC_ARB_STALL_CNT_EN, req 1 waits 7 cycles behind req 0's operation -> stall_cnt_o=7; without the macro, stall_cnt_o stays 0.

Source files
------------

// File: rtl/dummy_accelerator_arbiter.sv
// Round-robin arbiter sharing one accelerator among NumReq issue ports, one op in flight.
// Optional stall statistics counter enabled by `define DUMMY_ACC_ARB_STALL_CNT_EN.
module dummy_accelerator_arbiter #(
  parameter int NumReq    = 2,
  parameter int CtlWidth  = 32,
  parameter int DataWidth = 32,
  parameter int IdWidth   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*CtlWidth-1:0]    req_ctl_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  input  logic [NumReq-1:0]             rsp_ready_i,
  output logic [DataWidth-1:0]          rsp_data_o,
  output logic                          acc_valid_o,
  input  logic                          acc_ready_i,
  output logic [CtlWidth-1:0]           acc_ctl_o,
  output logic [DataWidth-1:0]          acc_data_o,
  input  logic                          acc_valid_i,
  output logic                          acc_ready_o,
  input  logic [DataWidth-1:0]          acc_data_i,
  output logic                          acc_flush_o,
  output logic                          busy_o,
  output logic [IdWidth-1:0]            owner_o,
  output logic [15:0]                   stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

  state_e               state;
  logic [IdWidth-1:0]   ptr, owner;
  logic [CtlWidth-1:0]  ctl_q;
  logic [DataWidth-1:0] data_q;

  logic [NumReq-1:0]    vld_rot;
  logic                 gnt_any;
  logic [IdWidth-1:0]   gnt_id;
  logic [CtlWidth-1:0]  gnt_ctl;
  logic [DataWidth-1:0] gnt_data;
  logic                 owner_rdy;

  // Rotate valids so that bit 0 is the requester at ptr; first set bit wins.
  always_comb begin
    vld_rot = NumReq'({req_valid_i, req_valid_i} >> ptr);
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (!gnt_any && vld_rot[k]) begin
        gnt_any = 1'b1;
        gnt_id  = IdWidth'((int'(ptr) + k) % NumReq);
      end
    end
  end

  always_comb begin
    gnt_ctl     = '0;
    gnt_data    = '0;
    owner_rdy   = 1'b0;
    req_ready_o = '0;
    rsp_valid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (IdWidth'(i) == gnt_id) begin
        gnt_ctl  = req_ctl_i[i*CtlWidth +: CtlWidth];
        gnt_data = req_data_i[i*DataWidth +: DataWidth];
        if (state == IDLE && gnt_any && !flush_i) req_ready_o[i] = 1'b1;
      end
      if (IdWidth'(i) == owner) begin
        owner_rdy = rsp_ready_i[i];
        if (state == WAIT_RSP && !flush_i) rsp_valid_o[i] = acc_valid_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      ctl_q  <= '0;
      data_q <= '0;
    end else if (flush_i) begin
      state  <= IDLE;
      owner  <= '0;
      ctl_q  <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          ctl_q  <= gnt_ctl;
          data_q <= gnt_data;
          owner  <= gnt_id;
          state  <= ISSUE;
        end
        // A result coincident with acc_ready_i is picked up in WAIT_RSP instead.
        ISSUE: if (acc_ready_i) state <= WAIT_RSP;
        WAIT_RSP: if (acc_valid_i && owner_rdy) begin
          ptr   <= IdWidth'((int'(owner) + 1) % NumReq);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign acc_valid_o = (state == ISSUE);
  assign acc_ctl_o   = ctl_q;
  assign acc_data_o  = data_q;
  assign acc_ready_o = (state == WAIT_RSP) && owner_rdy;
  assign rsp_data_o  = (state == WAIT_RSP) ? acc_data_i : '0;
  assign acc_flush_o = flush_i;
  assign busy_o      = (state != IDLE);
  assign owner_o     = owner;

`ifdef DUMMY_ACC_ARB_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                                   stall_q <= '0;
    else if (flush_i)                                              stall_q <= '0;
    else if (|req_valid_i && !(|req_ready_o) && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
